// File: rtl/mod_n_updown.sv
// Modulo-MOD up/down counter with parallel load, terminal count, wrap pulse and
// an optional one-shot RUN/DONE controller enabled by defining MOD_N_ONESHOT_EN.
module mod_n_updown #(
    parameter int WIDTH = 9,
    parameter int MOD   = 360
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             mode,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 32'sd1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    generate
        if ((MOD < 32'sd2) || (longint'(MOD) > (64'sd1 << WIDTH))) begin : g_bad_mod
            $error("mod_n_updown: MOD must satisfy 2 <= MOD <= 2**WIDTH");
        end
    endgenerate

    // Out-of-range load values saturate to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        if ({1'b0, val} < (WIDTH+1)'(MOD)) begin
            return val;
        end else begin
            return MAX_VAL;
        end
    endfunction

    logic [WIDTH-1:0] y_q, y_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] term_s;
    logic             at_term_s;
    logic             run_s;
    logic             hit_s;
    logic             tc_s;

    assign term_s    = up ? MAX_VAL : ZERO_VAL;
    assign at_term_s = (y_q == term_s);
    assign tc_s      = ce & at_term_s & run_s & ~ld;

`ifdef MOD_N_ONESHOT_EN
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   done_q, done_d;

    // A one-shot run ends on the edge that would otherwise wrap.
    assign hit_s = tc_s & mode;
    assign run_s = (state_q == ST_RUN);
    assign done  = done_q;

    // FSM state and completion flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // FSM next-state logic; only a load leaves DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (ld) begin
                    state_d = ST_RUN;
                end else if (hit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (ld) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM output logic: done follows the state being entered
    always_comb begin
        done_d = (state_d == ST_DONE);
    end
`else
    logic unused_mode_s;

    assign unused_mode_s = mode;
    assign hit_s         = 1'b0;
    assign run_s         = 1'b1;
    assign done          = 1'b0;
`endif

    // Count datapath: load beats counting, wrap only at the terminal value
    always_comb begin
        y_d    = y_q;
        wrap_d = 1'b0;
        if (ld) begin
            y_d = clamp_load(d);
        end else if (ce && run_s) begin
            if (hit_s) begin
                y_d = y_q;
            end else if (at_term_s) begin
                y_d    = up ? ZERO_VAL : MAX_VAL;
                wrap_d = 1'b1;
            end else if (up) begin
                y_d = y_q + ONE_VAL;
            end else begin
                y_d = y_q - ONE_VAL;
            end
        end else begin
            y_d    = y_q;
            wrap_d = 1'b0;
        end
    end

    // Count and wrap registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            y_q    <= ZERO_VAL;
            wrap_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            wrap_q <= wrap_d;
        end
    end

    assign y    = y_q;
    assign wrap = wrap_q;
    assign tc   = tc_s;

endmodule

// File: tb/tb_mod_n_updown.sv
// Bench for mod_n_updown: directed vector table, one-shot sequence, randomized
// run against an arithmetic reference model, and a two-digit decimal cascade.
module tb_mod_n_updown;

    localparam int W   = 9;
    localparam int M   = 360;
`ifdef MOD_N_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    typedef struct {
        bit       rst, ce, up, ld;
        int       d;
        bit       mode;
        int       ey;
        bit       etc, ewrap, edone;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, ce, up, ld, mode;
    logic [W-1:0] d;
    logic [W-1:0] y;
    logic         tc, wrap, done;

    logic         casc_ce;
    logic [3:0]   c0_y, c1_y;
    logic         c0_tc, c0_wrap, c0_done, c1_tc, c1_wrap, c1_done;

    int checks = 0;
    int errors = 0;

    int m_y    = 0;
    bit m_wrap = 1'b0;
    bit m_done = 1'b0;

    vec_t tv[$];

    always #5 clk = ~clk;

    mod_n_updown #(.WIDTH(W), .MOD(M)) dut (
        .clk(clk), .rst(rst), .ce(ce), .up(up), .ld(ld), .d(d), .mode(mode),
        .y(y), .tc(tc), .wrap(wrap), .done(done)
    );

    mod_n_updown #(.WIDTH(4), .MOD(10)) c0 (
        .clk(clk), .rst(rst), .ce(casc_ce), .up(1'b1), .ld(1'b0), .d(4'd0), .mode(1'b0),
        .y(c0_y), .tc(c0_tc), .wrap(c0_wrap), .done(c0_done)
    );

    mod_n_updown #(.WIDTH(4), .MOD(10)) c1 (
        .clk(clk), .rst(rst), .ce(c0_tc), .up(1'b1), .ld(1'b0), .d(4'd0), .mode(1'b0),
        .y(c1_y), .tc(c1_tc), .wrap(c1_wrap), .done(c1_done)
    );

    function automatic vec_t mk(bit r, bit c, bit u, bit l, int dd, bit m,
                                int ey, bit et, bit ew, bit ed);
        vec_t v;
        v.rst = r; v.ce = c; v.up = u; v.ld = l; v.d = dd; v.mode = m;
        v.ey = ey; v.etc = et; v.ewrap = ew; v.edone = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_tc();
        int term = up ? M - 1 : 0;
        return ce && !ld && !m_done && (m_y == term);
    endfunction

    task automatic model_next();
        int term = up ? M - 1 : 0;
        if (!rst) begin
            m_y = 0; m_wrap = 1'b0; m_done = 1'b0;
        end else if (ld) begin
            m_y = (int'(d) < M) ? int'(d) : M - 1;
            m_wrap = 1'b0; m_done = 1'b0;
        end else if (ce && !m_done) begin
            if (ONESHOT && mode && m_y == term) begin
                m_done = 1'b1; m_wrap = 1'b0;
            end else if (up) begin
                m_wrap = (m_y == M - 1);
                m_y    = (m_y + 1) % M;
            end else begin
                m_wrap = (m_y == 0);
                m_y    = (m_y + M - 1) % M;
            end
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input bit use_tab);
        bit exp_tc;
        rst = v.rst; ce = v.ce; up = v.up; ld = v.ld; d = W'(v.d); mode = v.mode;
        #1;
        exp_tc = use_tab ? v.etc : model_tc();
        chk("tc", int'(tc), int'(exp_tc));
        model_next();
        @(posedge clk);
        #1;
        chk("y",    int'(y),    use_tab ? v.ey          : m_y);
        chk("wrap", int'(wrap), use_tab ? int'(v.ewrap) : int'(m_wrap));
        chk("done", int'(done), use_tab ? int'(v.edone) : int'(m_done));
    endtask

    initial begin
        vec_t v;
        rst = 1'b0; ce = 1'b0; up = 1'b1; ld = 1'b0; d = '0; mode = 1'b0; casc_ce = 1'b0;

        // reset with ce/ld active, then count
        tv.push_back(mk(0,1,1,1,100,0,   0,0,0,0));
        tv.push_back(mk(0,1,1,1,100,0,   0,0,0,0));
        tv.push_back(mk(1,1,1,0,0,0,     1,0,0,0));
        tv.push_back(mk(1,1,1,0,0,0,     2,0,0,0));
        tv.push_back(mk(1,1,1,0,0,0,     3,0,0,0));
        // up wrap
        tv.push_back(mk(1,0,1,1,358,0, 358,0,0,0));
        tv.push_back(mk(1,1,1,0,0,0,   359,0,0,0));
        tv.push_back(mk(1,1,1,0,0,0,     0,1,1,0));
        tv.push_back(mk(1,1,1,0,0,0,     1,0,0,0));
        // down wrap, then direction flip
        tv.push_back(mk(1,0,0,1,1,0,     1,0,0,0));
        tv.push_back(mk(1,1,0,0,0,0,     0,0,0,0));
        tv.push_back(mk(1,1,0,0,0,0,   359,1,1,0));
        tv.push_back(mk(1,1,0,0,0,0,   358,0,0,0));
        tv.push_back(mk(1,1,1,0,0,0,   359,0,0,0));
        tv.push_back(mk(1,1,1,0,0,0,     0,1,1,0));
        tv.push_back(mk(1,0,1,0,0,0,     0,0,0,0));
        // load clamp, load beats ce, hold
        tv.push_back(mk(1,0,1,1,400,0, 359,0,0,0));
        tv.push_back(mk(1,1,1,1,7,0,     7,0,0,0));
        for (int i = 0; i < 5; i++) tv.push_back(mk(1,0,1,0,0,0, 7,0,0,0));
        // ld masks tc at terminal; tc needs ce
        tv.push_back(mk(1,0,1,1,359,0, 359,0,0,0));
        tv.push_back(mk(1,1,1,1,5,0,     5,0,0,0));
        tv.push_back(mk(1,0,0,1,0,0,     0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,     0,0,0,0));
        // reset mid-count and during load
        tv.push_back(mk(1,1,1,0,0,0,     1,0,0,0));
        tv.push_back(mk(0,1,1,0,0,0,     0,0,0,0));
        tv.push_back(mk(0,1,1,1,50,0,    0,0,0,0));
`ifdef MOD_N_ONESHOT_EN
        tv.push_back(mk(1,0,1,1,357,1, 357,0,0,0));
        tv.push_back(mk(1,1,1,0,0,1,   358,0,0,0));
        tv.push_back(mk(1,1,1,0,0,1,   359,0,0,0));
        tv.push_back(mk(1,1,1,0,0,1,   359,1,0,1));
        tv.push_back(mk(1,1,0,0,0,1,   359,0,0,1));
        tv.push_back(mk(1,1,1,0,0,0,   359,0,0,1));
        tv.push_back(mk(1,0,1,1,5,1,     5,0,0,0));
        tv.push_back(mk(1,1,1,0,0,1,     6,0,0,0));
`else
        tv.push_back(mk(1,0,1,1,359,1, 359,0,0,0));
        tv.push_back(mk(1,1,1,0,0,1,     0,1,1,0));
`endif

        foreach (tv[i]) run_vec(tv[i], 1'b1);

        // randomized run against the reference model
        for (int i = 0; i < 600; i++) begin
            v.rst  = ($urandom_range(0, 49) != 0);
            v.ce   = ($urandom_range(0, 3) != 0);
            v.up   = $urandom_range(0, 1) == 1;
            v.ld   = ($urandom_range(0, 15) == 0);
            v.mode = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 4))
                0:       v.d = 0;
                1:       v.d = 1;
                2:       v.d = M - 2;
                3:       v.d = M - 1;
                default: v.d = int'($urandom_range(0, 511));
            endcase
            run_vec(v, 1'b0);
        end

        // two-digit decimal cascade from reset
        ce = 1'b0; ld = 1'b0; mode = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1; casc_ce = 1'b1;
        chk("casc_reset_lo", int'(c0_y), 0);
        chk("casc_reset_hi", int'(c1_y), 0);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            chk("casc_lo",   int'(c0_y),    k % 10);
            chk("casc_hi",   int'(c1_y),    (k / 10) % 10);
            chk("casc_wrap", int'(c1_wrap), (k == 100) ? 1 : 0);
        end
        casc_ce = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_n_updown.md
# mod_n_updown

Parametrised modulo-N up/down counter: the next generation of the team's free-running `mod_n` counter. It adds runtime direction, synchronous parallel load, a terminal-count output for cascading, a registered wrap pulse, and an optional one-shot mode controlled by a small FSM. It serves as a timebase, address sequencer and angle or phase counter in the Basic_digital_components set.

## Interface

- `WIDTH`, default 9: counter width in bits.
- `MOD`, default 360: modulus N, i.e. `y` ranges over 0..MOD-1. Elaboration fails unless 2 ≤ MOD ≤ 2^WIDTH.

- `clk`   in   1   rising-edge clock; the only clock.
- `rst`   in   1   synchronous, active-low reset, sampled on `clk` rising edge.
- `ce`    in   1   count enable.
- `up`    in   1   direction: 1 = increment, 0 = decrement.
- `ld`    in   1   synchronous parallel load.
- `d`     in   WIDTH   load value.
- `mode`  in   1   1 = one-shot, 0 = free-running. Only effective with `MOD_N_ONESHOT_EN`.
- `y`     out  WIDTH   registered count.
- `tc`    out  1   terminal count. Combinational. Drives the `ce` of a cascaded counter.
- `wrap`  out  1   registered one-cycle pulse, high while `y` shows a wrapped value.
- `done`  out  1   registered one-shot completion flag.

## Operation

- Terminal value: MOD-1 when `up`=1; 0 when `up`=0.
- Per-edge priority: `rst`=0 > `ld` > (`ce` and state RUN) > hold.
- Reset: `y`=0, `wrap`=0, `done`=0, state RUN.
- Load: `y` ← `d` if `d` < MOD, else `y` ← MOD-1 (clamp). State → RUN, `done`=0, `wrap`=0. `ld` overrides `ce` in the same cycle.
- Count in RUN with `ce`=1:
  - Up: `y`+1. At MOD-1, wraps to 0.
  - Down: `y`-1. At 0, wraps to MOD-1.
  - Arithmetic is mod MOD, never mod 2^WIDTH. `y` ≥ MOD is unreachable.
- `up` may change on any cycle. The new direction applies at the next edge. No extra latency.
- `ce`=0: `y` holds and `wrap` deasserts.
- `tc` = `ce` & (`y` == terminal value) & (state == RUN) & !`ld`.
- `wrap`: set on the edge where `y` wraps; cleared on every other edge.
- FSM, present only with `MOD_N_ONESHOT_EN`:
  - States are RUN and DONE.
  - RUN → DONE when `mode`=1, `ce`=1, `y` == terminal and `ld`=0. On that edge `y` stays at the terminal value, does not wrap, `wrap` stays 0, and `done` ← 1.
  - DONE ignores `ce`, `up` and `mode`. `y` holds, `done`=1 and `tc`=0.
  - DONE → RUN only via `ld` (`done` ← 0) or reset.
  - `mode`=0 in RUN gives free-running behaviour.

## Timing

- All outputs except `tc` change only on the `clk` rising edge.
- `ld`/`ce` to `y`: 1 cycle.
- Reset: `rst` low at edge k gives reset values from edge k. `rst` asserted mid-count or during `ld` wins.
- `wrap` is coincident with the first cycle of the wrapped `y` value and lasts exactly 1 cycle per wrap. With MOD=2 and `ce` held high, `wrap` toggles.
- `tc` follows `ce`/`up`/`y` combinationally within the same cycle. Cascade: stage n+1 `ce` = stage n `tc` gives a correct multi-digit count with no added latency.
- `done` rises one edge after the cycle in which `tc` was high in one-shot mode.

## Configuration

- `MOD_N_ONESHOT_EN` defined:
  - The RUN/DONE FSM and the `mode` input are functional.
- `MOD_N_ONESHOT_EN` undefined:
  - No FSM is built and the counter is always free-running.
  - `mode` is ignored and left unconnected internally.
  - `done` is tied to 0.
  - All other behaviour is identical.

## Test plan

- Reset: `rst`=0 for 2 cycles with `ce`=1, `ld`=1, `d`=100 → `y`=0, `wrap`=0, `done`=0. After release with `ce`=1, `up`=1 → `y`=1, 2, 3.
- Up wrap, MOD=360: `ld` `d`=358, then `ce`=1, `up`=1 → `y`=358, 359, 0, 1. `tc`=1 only while `y`=359. `wrap`=1 only while `y`=0.
- Down wrap: `ld` `d`=1, `up`=0 → `y`=1, 0, 359, 358. `tc`=1 while `y`=0. `wrap`=1 while `y`=359. Flip `up` to 1 at `y`=358 → next `y`=359.
- Load rules: `ld` `d`=400 → `y`=359. `ld`+`ce` with `d`=7 → `y`=7, not 8. `ce`=0 for 5 cycles → `y` unchanged, `wrap`=0.
- One-shot (macro defined): `mode`=1, `ld` `d`=357, `ce`=1, `up`=1 → `y`=358, 359, 359, 359. `done`=1 from the cycle after `tc`. `wrap` never set. Then `ld` `d`=5 → `y`=5, `done`=0, counting resumes.
- Cascade: two instances, MOD=10, WIDTH=4, stage 2 `ce` = stage 1 `tc`. Run 100 cycles from reset → pair reads 00→99→00, and stage-2 `wrap` pulses once at cycle 100.
